disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter SLICE, default 50000000; maximum grant cycles while another requester waits (1 s at 50 MHz).
REQ-002 Parameter BLINK_HALF, default 25000000; blink half-period in cycles.
REQ-003 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 rst  input  1  one clock; reset is synchronous and active-high.
REQ-005 i_req  input  3  per-source display request, bit k = source k.
REQ-006 i_seg0, i_seg1, i_seg2  input  42 each  six-digit segment pattern of source k, 7 bits per digit, digit 0 in bits [6:0].
REQ-007 i_dp0, i_dp1, i_dp2  input  6 each  decimal-point pattern of source k.
REQ-008 i_blink  input  3  bit k set: source k's content blinks while it owns the display.
REQ-009 o_gnt  output  3  one-hot grant; all-zero when idle.
REQ-010 o_six_digit_seg  output  42  pattern fed to the led_disp i_six_digit_seg port.
REQ-011 o_six_dp  output  6  pattern fed to the led_disp i_six_dp port.
REQ-012 o_busy  output  1  high while any grant is held.

Function
REQ-013 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner, index in 2-bit register own).
REQ-014 IDLE: if i_req is nonzero, the block SHALL grant the first requester in round-robin order starting at last+1 mod 3 and enter GRANT; o_gnt SHALL be asserted on the next cycle (1-cycle latency).
REQ-015 On every grant, the block SHALL set last to the new owner and clear the slice counter cnt.
REQ-016 GRANT: cnt SHALL increment each cycle and saturate at SLICE-1.
REQ-017 GRANT: when i_req[own] is low and another request is pending, the block SHALL hand over directly to the next round-robin requester after own, with no idle cycle.
REQ-018 GRANT: when i_req[own] is low and no other request is pending, the block SHALL return to IDLE and clear o_gnt on the next cycle.
REQ-019 GRANT: when cnt equals SLICE-1, i_req[own] is high and another request is pending, the block SHALL preempt and grant the next round-robin requester after own.
REQ-020 When cnt is saturated and the owner is the only requester, the block SHALL keep the grant indefinitely; a later request from another source SHALL cause preemption on the cycle after it appears.
REQ-021 On simultaneous requests, the block SHALL follow round-robin order only, with no fixed priority.
REQ-022 o_six_digit_seg and o_six_dp SHALL be registered copies of the owner's i_segk/i_dpk (1-cycle latency) and SHALL follow the new owner's data in the same cycle o_gnt changes.
REQ-023 In IDLE, o_six_digit_seg and o_six_dp SHALL be all-zero (blank).
REQ-024 Blink phase SHALL be a free-running counter toggling every BLINK_HALF cycles, starting at phase 0 (visible) after reset.
REQ-025 While i_blink[own] is high and the blink phase is 1, o_six_digit_seg and o_six_dp SHALL be all-zero; o_gnt SHALL be unaffected.
REQ-026 The blink counter SHALL NOT restart on a grant change.
REQ-027 o_busy SHALL equal the OR of the o_gnt bits.

Reset
REQ-028 While rst is high, the block SHALL drive o_gnt=0, o_busy=0, o_six_digit_seg=0, o_six_dp=0, and reset state=IDLE, cnt=0, blink counter=0, blink phase=0, last=2 (so source 0 wins first).
REQ-029 rst asserted during GRANT SHALL take effect at the next edge and drop the grant immediately; no partial hand-over SHALL follow.
REQ-030 After rst deasserts, the first grant SHALL occur one cycle after a request is sampled.

Verification (SLICE=8, BLINK_HALF=4)
REQ-031 rst, then i_req=3'b111 held -> o_gnt sequence 001 for 8 cycles, then 010 for 8 cycles, then 100 for 8 cycles, repeating.
REQ-032 i_req=3'b010 alone for 20 cycles -> o_gnt=010 throughout; i_req[0] raised after cnt saturates -> o_gnt=001 one cycle later.
REQ-033 Owner 0 with i_seg0=42'h155_5555_5555 and i_dp0=6'h21 -> outputs equal those values one cycle later; owner drops i_req, nothing pending -> outputs 0 and o_busy=0 next cycle.
REQ-034 Owner 1 with i_blink[1]=1 and i_seg1 nonzero -> o_six_digit_seg alternates i_seg1 / 0 every 4 cycles while o_gnt stays 010.
REQ-035 rst pulsed for 1 cycle mid-grant of source 2 -> all outputs 0 next cycle; with i_req=3'b111 afterwards, the first grant goes to source 0.
REQ-036 Owner 0 releases while i_req[2] is high -> o_gnt changes 001 to 100 with no 000 cycle.

Source files
------------

// File: rtl/disp_sched.sv
// Round-robin display arbiter: three sources share one six-digit LED display,
// with a time slice for preemption and an optional per-source blink mask.
//
// state | meaning
// IDLE  | no owner; display blank, grant all-zero
// GRANT | own_q holds the display; cnt_q counts slice cycles (saturating)
module disp_sched #(
    parameter int SLICE      = 50000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_req,
    input  logic [41:0] i_seg0,
    input  logic [41:0] i_seg1,
    input  logic [41:0] i_seg2,
    input  logic [5:0]  i_dp0,
    input  logic [5:0]  i_dp1,
    input  logic [5:0]  i_dp2,
    input  logic [2:0]  i_blink,
    output logic [2:0]  o_gnt,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic        o_busy
);

    localparam int CW = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SLICE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    own_q, own_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [41:0]   seg_q, seg_d;
    logic [5:0]    dp_q, dp_d;
    logic          busy_q;
    logic          new_grant;
    logic [2:0]    others;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] x);
        case (x)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // First set bit of req scanning first, first+1, first+2 (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] first);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = inc3(first);
        c2 = inc3(c1);
        if (|(req & onehot(first))) return first;
        else if (|(req & onehot(c1))) return c1;
        else return c2;
    endfunction

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        new_grant = 1'b0;
        others    = i_req & ~onehot(own_q);

        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    own_d     = rr_pick(i_req, inc3(last_q));
                    state_d   = GRANT;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!(|(i_req & onehot(own_q)))) begin
                    if (|others) begin
                        own_d     = rr_pick(others, inc3(own_q));
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_MAX && |others) begin
                    own_d     = rr_pick(others, inc3(own_q));
                    new_grant = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_grant) begin
            last_d = own_d;
            cnt_d  = '0;
        end

        bcnt_d  = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + BW'(1);
        phase_d = (bcnt_q == BLINK_MAX) ? ~phase_q : phase_q;

        gnt_d = '0;
        seg_d = '0;
        dp_d  = '0;
        if (state_d == GRANT) begin
            gnt_d = onehot(own_d);
            // Mask uses the phase the outputs will be shown with.
            if (!(|(i_blink & gnt_d) && phase_d)) begin
                case (own_d)
                    2'd0:    begin seg_d = i_seg0; dp_d = i_dp0; end
                    2'd1:    begin seg_d = i_seg1; dp_d = i_dp1; end
                    default: begin seg_d = i_seg2; dp_d = i_dp2; end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= 2'd0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            gnt_q   <= '0;
            seg_q   <= '0;
            dp_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            gnt_q   <= gnt_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= |gnt_d;
        end
    end

    assign o_gnt           = gnt_q;
    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with SLICE=8, BLINK_HALF=4.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  i_req = '0;
    logic [41:0] i_seg0 = '0, i_seg1 = '0, i_seg2 = '0;
    logic [5:0]  i_dp0 = '0, i_dp1 = '0, i_dp2 = '0;
    logic [2:0]  i_blink = '0;
    logic [2:0]  o_gnt;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [41:0] SEG_A = 42'h155_5555_5555;
    localparam logic [41:0] SEG_B = 42'h2AA_AAAA_AAAA;
    localparam logic [41:0] SEG_C = 42'h0F0_F0F0_F0F0;

    disp_sched #(.SLICE(8), .BLINK_HALF(4)) dut (
        .clk(clk), .rst(rst), .i_req(i_req),
        .i_seg0(i_seg0), .i_seg1(i_seg1), .i_seg2(i_seg2),
        .i_dp0(i_dp0), .i_dp1(i_dp1), .i_dp2(i_dp2),
        .i_blink(i_blink), .o_gnt(o_gnt),
        .o_six_digit_seg(o_six_digit_seg), .o_six_dp(o_six_dp), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One reset cycle; returns at the negedge right after it, rst low.
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        i_req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0]  exp_gnt;
        logic [41:0] exp_seg;

        i_seg0 = SEG_A; i_seg1 = SEG_B; i_seg2 = SEG_C;
        i_dp0  = 6'h21; i_dp1  = 6'h12; i_dp2  = 6'h3F;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",  64'(o_gnt), 64'h0);
        chk("rst_seg",  64'(o_six_digit_seg), 64'h0);
        chk("rst_dp",   64'(o_six_dp), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);

        // All three request continuously: 8-cycle slices in order 0,1,2.
        rst   = 1'b0;
        i_req = 3'b111;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            case ((k / 8) % 3)
                0:       begin exp_gnt = 3'b001; exp_seg = SEG_A; end
                1:       begin exp_gnt = 3'b010; exp_seg = SEG_B; end
                default: begin exp_gnt = 3'b100; exp_seg = SEG_C; end
            endcase
            chk($sformatf("rr_gnt[%0d]", k), 64'(o_gnt), 64'(exp_gnt));
            if (k % 4 == 0) chk($sformatf("rr_seg[%0d]", k), 64'(o_six_digit_seg), 64'(exp_seg));
        end
        chk("rr_busy", 64'(o_busy), 64'h1);

        // Source 1 alone with blink: grant held past saturation, content blinks.
        do_reset();
        i_req   = 3'b010;
        i_blink = 3'b010;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk($sformatf("solo_gnt[%0d]", n), 64'(o_gnt), 64'h2);
            exp_seg = (((n / 4) % 2) == 1) ? 42'h0 : SEG_B;
            chk($sformatf("blink_seg[%0d]", n), 64'(o_six_digit_seg), 64'(exp_seg));
            if (n == 5) chk("blink_dp", 64'(o_six_dp), 64'h0);
        end
        i_req = 3'b011;
        @(negedge clk);
        chk("preempt_sat_gnt", 64'(o_gnt), 64'h1);
        chk("preempt_sat_seg", 64'(o_six_digit_seg), 64'(SEG_A));
        i_blink = 3'b000;

        // Owner 0 data path, then release to idle.
        do_reset();
        i_req = 3'b001;
        @(negedge clk);
        chk("own0_gnt",  64'(o_gnt), 64'h1);
        chk("own0_seg",  64'(o_six_digit_seg), 64'(SEG_A));
        chk("own0_dp",   64'(o_six_dp), 64'h21);
        chk("own0_busy", 64'(o_busy), 64'h1);
        i_req = 3'b000;
        @(negedge clk);
        chk("idle_gnt",  64'(o_gnt), 64'h0);
        chk("idle_seg",  64'(o_six_digit_seg), 64'h0);
        chk("idle_dp",   64'(o_six_dp), 64'h0);
        chk("idle_busy", 64'(o_busy), 64'h0);

        // Direct hand-over 0 -> 2 with no idle cycle.
        i_req = 3'b001;
        @(negedge clk);
        chk("ho_pre_gnt", 64'(o_gnt), 64'h1);
        i_req = 3'b100;
        @(negedge clk);
        chk("ho_gnt",  64'(o_gnt), 64'h4);
        chk("ho_seg",  64'(o_six_digit_seg), 64'(SEG_C));
        chk("ho_dp",   64'(o_six_dp), 64'h3F);
        chk("ho_busy", 64'(o_busy), 64'h1);

        // Reset pulse mid-grant of source 2; source 0 wins afterwards.
        do_reset();
        i_req = 3'b100;
        @(negedge clk);
        chk("g2_gnt", 64'(o_gnt), 64'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt",  64'(o_gnt), 64'h0);
        chk("midrst_seg",  64'(o_six_digit_seg), 64'h0);
        chk("midrst_busy", 64'(o_busy), 64'h0);
        rst   = 1'b0;
        i_req = 3'b111;
        @(negedge clk);
        chk("postrst_gnt", 64'(o_gnt), 64'h1);
        chk("postrst_seg", 64'(o_six_digit_seg), 64'(SEG_A));

        // Release with both others pending: next after owner 0 is source 1.
        i_req = 3'b110;
        @(negedge clk);
        chk("rel_rr_gnt", 64'(o_gnt), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
